// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, de_reg stop codes, issue FSM states
// and the decoded-field bundle produced by ins_split.
package pipe_pkg;

  localparam logic [5:0] BUBBLE_OP = 6'd55;
  localparam logic [5:0] LOAD_OP   = 6'd16;
  localparam logic [5:0] HALT_OP   = 6'd63;

  localparam logic [1:0] STOP_RUN   = 2'b01;
  localparam logic [1:0] STOP_FLUSH = 2'b10;
  localparam logic [1:0] STOP_FIN   = 2'b00;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_FLUSH,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [10:0] aux;
    logic [31:0] imm_dpl;
  } fields_t;

endpackage

// File: rtl/fd_issue_if.sv
// Fetch handshake, register-file read port and de_reg producer bundle.
// master = the issue stage, slave = its environment.
interface fd_issue_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic        redirect;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [1:0]  stop_d;
  logic [31:0] pc_out;
  logic [5:0]  op_out;
  logic [4:0]  rt_out;
  logic [4:0]  rd_out;
  logic [10:0] aux_out;
  logic [31:0] imm_dpl_out;
  logic [31:0] os_out;
  logic [31:0] ot_out;

  modport master (
    input  if_valid, if_ins, if_pc, redirect, rs_data, rt_data,
    output if_ready, rs_addr, rt_addr, stop_d, pc_out, op_out, rt_out,
           rd_out, aux_out, imm_dpl_out, os_out, ot_out
  );

  modport slave (
    output if_valid, if_ins, if_pc, redirect, rs_data, rt_data,
    input  if_ready, rs_addr, rt_addr, stop_d, pc_out, op_out, rt_out,
           rd_out, aux_out, imm_dpl_out, os_out, ot_out
  );
endinterface

// File: rtl/ins_split.sv
// Combinational instruction field splitter with 16-bit displacement sign extension.
module ins_split
  import pipe_pkg::*;
(
  input  logic [31:0] ins,
  output fields_t     f
);

  assign f.op      = ins[31:26];
  assign f.rs      = ins[25:21];
  assign f.rt      = ins[20:16];
  assign f.rd      = ins[15:11];
  assign f.aux     = ins[10:0];
  assign f.imm_dpl = {{16{ins[15]}}, ins[15:0]};

endmodule

// File: rtl/fd_issue.sv
// Fetch-to-decode issue stage: latches the fetch word, reads the register file
// and owns all stop_d sequencing (load-use bubble, branch flush, halt).
module fd_issue #(
  parameter logic [5:0] BUBBLE_OP = pipe_pkg::BUBBLE_OP,
  parameter logic [5:0] LOAD_OP   = pipe_pkg::LOAD_OP,
  parameter logic [5:0] HALT_OP   = pipe_pkg::HALT_OP
) (
  input  logic       clk,
  input  logic       rstd,
  fd_issue_if.master bus
);
  import pipe_pkg::*;

  state_e      state_q, state_d;
  logic [31:0] ins_q, pc_q;
  logic        vld_q, prev_load_q;
  logic [4:0]  prev_rt_q;
  fields_t     f;

  logic        hazard, is_halt;
  logic        ready, issue, flush;
  logic [1:0]  stop;
  logic        accept;

  ins_split u_split (.ins(ins_q), .f(f));

  assign hazard  = vld_q & prev_load_q & ((prev_rt_q == f.rs) | (prev_rt_q == f.rt));
  assign is_halt = vld_q & (f.op == HALT_OP);
  // The word offered during a redirect cycle is on the wrong path and is dropped.
  assign accept  = bus.if_valid & ready & ~flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rstd) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if      (bus.redirect) state_d = ST_FLUSH;
        else if (hazard)       state_d = ST_STALL;
        else if (is_halt)      state_d = ST_DONE;
      end
      ST_STALL: begin
        if      (bus.redirect) state_d = ST_FLUSH;
        else if (is_halt)      state_d = ST_DONE;
        else                   state_d = ST_RUN;
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    ready = 1'b1;
    stop  = STOP_RUN;
    issue = 1'b0;
    flush = 1'b0;
    unique case (state_q)
      ST_RUN, ST_STALL: begin
        if (bus.redirect) begin
          flush = 1'b1;
          stop  = STOP_FLUSH;
        end else if (state_q == ST_RUN && hazard) begin
          ready = 1'b0;
        end else if (is_halt) begin
          stop = STOP_FIN;
        end else begin
          issue = vld_q;
        end
      end
      ST_FLUSH: ;
      ST_DONE: begin
        ready = 1'b0;
        stop  = STOP_FIN;
      end
      default: ;
    endcase
  end

  // The latch only drops its word once consumed (issue, bubble, halt or flush);
  // a hazard deasserts ready and holds it for the stall cycle.
  always_ff @(posedge clk) begin
    if (rstd) begin
      ins_q       <= '0;
      pc_q        <= '0;
      vld_q       <= 1'b0;
      prev_load_q <= 1'b0;
      prev_rt_q   <= '0;
    end else begin
      if (accept) begin
        ins_q <= bus.if_ins;
        pc_q  <= bus.if_pc;
        vld_q <= 1'b1;
      end else if (ready) begin
        vld_q <= 1'b0;
      end
      if (issue) begin
        prev_load_q <= (f.op == LOAD_OP);
        prev_rt_q   <= f.rt;
      end else begin
        prev_load_q <= 1'b0;
      end
    end
  end

  assign bus.if_ready    = ready;
  assign bus.stop_d      = stop;
  assign bus.op_out      = issue ? f.op : BUBBLE_OP;
  assign bus.rs_addr     = f.rs;
  assign bus.rt_addr     = f.rt;
  assign bus.pc_out      = pc_q;
  assign bus.rt_out      = f.rt;
  assign bus.rd_out      = f.rd;
  assign bus.aux_out     = f.aux;
  assign bus.imm_dpl_out = f.imm_dpl;
  assign bus.os_out      = bus.rs_data;
  assign bus.ot_out      = bus.rt_data;

endmodule

// File: tb/tb_fd_issue.sv
// Scoreboard bench for fd_issue: a slot-based reference model predicts each
// cycle's de_reg outputs; a negedge monitor compares them with the DUT.
module tb_fd_issue;

  logic clk  = 1'b0;
  logic rstd = 1'b1;
  always #5 clk = ~clk;

  fd_issue_if bus ();

  fd_issue dut (
    .clk  (clk),
    .rstd (rstd),
    .bus  (bus)
  );

  logic [31:0] regs [32];
  assign bus.rs_data = regs[bus.rs_addr];
  assign bus.rt_data = regs[bus.rt_addr];

  typedef struct {
    logic [1:0]  stop;
    logic [5:0]  op;
    logic        ready;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [31:0] pc;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [10:0] aux;
    logic [31:0] imm;
    logic [31:0] os;
    logic [31:0] ot;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  // Reference model: one fetch slot, the rt of a just-issued load (-1 if none),
  // and two sticky modes (flushing for one cycle, halted until reset).
  bit          m_vld, m_flush, m_halt;
  logic [31:0] m_ins, m_pc;
  int          m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_vld   = 0;
    m_flush = 0;
    m_halt  = 0;
    m_ins   = '0;
    m_pc    = '0;
    m_last  = -1;
  endfunction

  function automatic void model_step(input bit v, input logic [31:0] ins,
                                     input logic [31:0] pc, input bit redir);
    exp_t e;
    int   op, rs, rt, disp;
    bit   take;
    op   = int'(m_ins[31:26]);
    rs   = int'(m_ins[25:21]);
    rt   = int'(m_ins[20:16]);
    disp = int'(m_ins[15:0]);
    if (disp >= 32768) disp -= 65536;
    e.rs_a  = m_ins[25:21];
    e.rt_a  = m_ins[20:16];
    e.pc    = m_pc;
    e.rt    = m_ins[20:16];
    e.rd    = m_ins[15:11];
    e.aux   = m_ins[10:0];
    e.imm   = 32'(disp);
    e.os    = regs[rs];
    e.ot    = regs[rt];
    e.stop  = 2'b01;
    e.op    = 6'd55;
    e.ready = 1'b1;
    take    = 0;
    if (m_halt) begin
      e.stop  = 2'b00;
      e.ready = 1'b0;
    end else if (m_flush) begin
      m_flush = 0;
      m_last  = -1;
      take    = 1;
    end else if (redir) begin
      e.stop  = 2'b10;
      m_vld   = 0;
      m_last  = -1;
      m_flush = 1;
    end else if (!m_vld) begin
      m_last = -1;
      take   = 1;
    end else if (m_last >= 0 && (m_last == rs || m_last == rt)) begin
      e.ready = 1'b0;
      m_last  = -1;
    end else if (op == 63) begin
      e.stop = 2'b00;
      m_halt = 1;
      take   = 1;
    end else begin
      e.op   = 6'(op);
      m_last = (op == 16) ? rt : -1;
      take   = 1;
    end
    if (take) begin
      m_vld = v;
      if (v) begin
        m_ins = ins;
        m_pc  = pc;
      end
    end
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stop_d",      32'(bus.stop_d),      32'(e.stop));
      check("op_out",      32'(bus.op_out),      32'(e.op));
      check("if_ready",    32'(bus.if_ready),    32'(e.ready));
      check("rs_addr",     32'(bus.rs_addr),     32'(e.rs_a));
      check("rt_addr",     32'(bus.rt_addr),     32'(e.rt_a));
      check("pc_out",      bus.pc_out,           e.pc);
      check("rt_out",      32'(bus.rt_out),      32'(e.rt));
      check("rd_out",      32'(bus.rd_out),      32'(e.rd));
      check("aux_out",     32'(bus.aux_out),     32'(e.aux));
      check("imm_dpl_out", bus.imm_dpl_out,      e.imm);
      check("os_out",      bus.os_out,           e.os);
      check("ot_out",      bus.ot_out,           e.ot);
    end
  end

  function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int lo16);
    logic [31:0] w;
    w = {6'(op), 5'(rs), 5'(rt), 16'(lo16)};
    return w;
  endfunction

  function automatic logic [31:0] rr(input int rs, input int rt, input int rd);
    return mk(0, rs, rt, rd << 11);
  endfunction

  task automatic cycle(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit redir);
    @(posedge clk);
    #1;
    rstd         = 1'b0;
    bus.if_valid = v;
    bus.if_ins   = ins;
    bus.if_pc    = pc;
    bus.redirect = redir;
    model_step(v, ins, pc, redir);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rstd         = 1'b1;
    bus.if_valid = 1'b0;
    bus.redirect = 1'b0;
    model_reset();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 32'h0, 32'h0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
    bus.if_valid = 1'b0;
    bus.if_ins   = '0;
    bus.if_pc    = '0;
    bus.redirect = 1'b0;
    model_reset();
    do_reset();

    // add r3,r1,r2 @0x40 issues the cycle after it is accepted
    cycle(1, rr(1, 2, 3), 32'h40, 0);
    cycle(0, 32'h0, 32'h0, 0);
    idle(1);

    // lw r5 followed by dependent add r6,r5,r1: one bubble, then the add
    cycle(1, mk(16, 1, 5, 4), 32'h44, 0);
    cycle(1, rr(5, 1, 6), 32'h48, 0);
    cycle(1, mk(0, 7, 8, 16'hFFFC), 32'h4C, 0);
    cycle(1, mk(0, 7, 8, 16'hFFFC), 32'h4C, 0);
    cycle(1, mk(0, 9, 10, 16'h7FFF), 32'h50, 0);
    idle(2);

    // back-to-back dependent loads, then a consumer: one bubble each
    cycle(1, mk(16, 2, 5, 0), 32'h60, 0);
    cycle(1, mk(16, 5, 6, 8), 32'h64, 0);
    cycle(1, rr(6, 0, 7), 32'h68, 0);
    cycle(1, rr(6, 0, 7), 32'h68, 0);
    idle(3);

    // redirect with an instruction latched: flush, bubble, then the target
    cycle(1, rr(1, 2, 4), 32'h80, 0);
    cycle(1, rr(2, 3, 5), 32'h84, 1);
    cycle(1, rr(3, 4, 6), 32'h200, 0);
    idle(2);

    // halt: stop_d = 00 held, redirect ignored, reset recovers
    cycle(1, mk(63, 0, 0, 0), 32'h90, 0);
    cycle(1, rr(1, 1, 1), 32'h94, 0);
    for (int i = 0; i < 4; i++) cycle(1, rr(2, 2, 2), 32'h98, i[0]);
    do_reset();
    idle(2);

    // halt and redirect together: redirect wins, execution continues
    cycle(1, mk(63, 0, 0, 0), 32'hA0, 0);
    cycle(0, 32'h0, 32'h0, 1);
    cycle(1, rr(1, 2, 9), 32'h300, 0);
    idle(2);

    // halt behind a load-use hazard: bubble first, then finish
    cycle(1, mk(16, 0, 4, 0), 32'hB0, 0);
    cycle(1, mk(63, 4, 0, 0), 32'hB4, 0);
    idle(4);
    do_reset();

    // randomized stream with small register indices to provoke hazards
    for (int i = 0; i < 800; i++) begin
      int          sel, op;
      logic [31:0] w;
      if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        sel = $urandom_range(0, 15);
        if      (sel < 6)  op = 0;
        else if (sel < 11) op = 16;
        else if (sel == 11) op = ($urandom_range(0, 3) == 0) ? 63 : 16;
        else                op = $urandom_range(0, 62);
        w = mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535));
        cycle($urandom_range(0, 4) != 0, w, $urandom, $urandom_range(0, 11) == 0);
      end
    end
    idle(2);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/fd_issue.md
# fd_issue

Fetch-to-decode issue stage: latches the instruction word from fetch, splits and sign-extends its fields, reads the register file, and drives the full producer side of `de_reg` (`pc`, `op`, `rt`, `rd`, `aux`, `imm_dpl`, `os`, `ot`, `stop_d`). It owns all `stop_d` sequencing for `de_reg`:
- bubble insertion on load-use hazards;
- the one-cycle branch flush;
- the terminal halt.

It sits between the fetch unit and `de_reg`.

## Interface
Parameters:
- `BUBBLE_OP`, 6'd55: opcode `de_reg` treats as no-op.
- `LOAD_OP`, 6'd16: opcode that writes `rt` from memory (hazard source).
- `HALT_OP`, 6'd63: opcode that ends execution.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rstd`  in  1  reset; synchronous, active-high in this block.
- `if_valid`  in  1  fetch presents `if_ins`/`if_pc`.
- `if_ready`  out  1  this block accepts the fetch word on this edge.
- `if_ins`  in  32  instruction word.
- `if_pc`  in  32  PC of `if_ins`.
- `redirect`  in  1  taken branch/jump resolved downstream this cycle.
- `rs_addr`, `rt_addr`  out  5  register-file read addresses (combinational).
- `rs_data`, `rt_data`  in  32  register-file read data, same cycle.
- `stop_d`  out  2  [1] = flush, [0] = continue; 2'b00 = finish.
- `pc_out`  out  32  PC to `de_reg`.
- `op_out`  out  6  opcode to `de_reg`.
- `rt_out`  out  5  rt field.
- `rd_out`  out  5  rd field.
- `aux_out`  out  11  ins[10:0].
- `imm_dpl_out`  out  32  sign-extended ins[15:0].
- `os_out`  out  32  = `rs_data`.
- `ot_out`  out  32  = `rt_data`.

## Operation
- Internal latch holds `ins_q`, `pc_q`, `vld_q`. It also holds `prev_load_q`/`prev_rt_q`, describing the last instruction issued to `de_reg`.
- Field split of `ins_q`:
  - op = [31:26], rs = [25:21], rt = [20:16], rd = [15:11], aux = [10:0].
  - `imm_dpl` = {{16{ins_q[15]}}, ins_q[15:0]}.
- `rs_addr`/`rt_addr` are driven from `ins_q`.
- FSM states: RUN, STALL, FLUSH, DONE.
  - **RUN**:
    - `if_ready` = 1. The latch loads on `if_valid & if_ready`.
    - `vld_q` = 0 → `op_out` = `BUBBLE_OP`, `stop_d` = 01.
    - Hazard: `vld_q` & `prev_load_q` & (`prev_rt_q` == rs or == rt). Then `op_out` = `BUBBLE_OP`, `stop_d` = 01, `if_ready` = 0, go to STALL.
    - Op == `HALT_OP` (no hazard): `stop_d` = 00, `op_out` = `BUBBLE_OP`, go to DONE.
    - Otherwise issue: fields out, `stop_d` = 01.
  - **STALL** (exactly 1 cycle):
    - Clear `prev_load_q`. Outputs are as RUN with no hazard; the held instruction issues. Return to RUN.
    - `if_ready` = 1.
  - **FLUSH**:
    - `stop_d` = 00 is never driven here; `stop_d` = 01 with `op_out` = `BUBBLE_OP`.
    - `if_ready` = 1. The accepted word is loaded, since `de_reg` ignores this cycle itself.
    - Return to RUN.
  - **DONE**: `stop_d` = 00, `op_out` = `BUBBLE_OP`, `if_ready` = 0. Held until reset.
- `redirect` in RUN or STALL has priority over hazard and halt:
  - `stop_d` = 10, `op_out` = `BUBBLE_OP`.
  - `vld_q` and `prev_load_q` cleared; the latched instruction is discarded.
  - `if_ready` = 1, but the incoming word is dropped.
  - Go to FLUSH.
- `redirect` in DONE is ignored.
- `prev_load_q`/`prev_rt_q` update only on a real issue. A bubble clears `prev_load_q`.

## Timing
- Latency: a word accepted at edge N drives `de_reg` inputs during cycle N+1, captured at edge N+1.
- Register-file path is combinational; `os_out`/`ot_out` follow `rs_data`/`rt_data` in the same cycle.
- Reset values on the edge with `rstd` = 1:
  - state RUN; `vld_q` = 0, `prev_load_q` = 0, `ins_q` = 0, `pc_q` = 0.
  - Hence `op_out` = `BUBBLE_OP`, `stop_d` = 01, `if_ready` = 1.
  - All data outputs derive from zeroed latches, giving 0.
- Reset mid-STALL, mid-FLUSH or in DONE returns to RUN with no pending issue.
- Load-use costs exactly one bubble. Back-to-back loads with dependency: one bubble each.
- Halt behind a hazard: bubble first, then `stop_d` = 00 next cycle.
- Redirect and halt in the same cycle: redirect wins, no DONE.

## Structure
- Shared package `pipe_pkg` holds:
  - opcode localparams (`BUBBLE_OP`, `LOAD_OP`, `HALT_OP`);
  - the `stop_d` encodings (STOP_RUN = 01, STOP_FLUSH = 10, STOP_FIN = 00);
  - the FSM state enum.
- One natural sub-module: `ins_split`, a combinational field splitter and sign-extender, reused by other stages.

## Test plan
- Reset, then `if_ins` = add r3,r1,r2 @ pc 0x40 → next cycle: `op_out` = 0, `rd_out` = 3, `pc_out` = 0x40, `stop_d` = 01, `os_out` = `rs_data`.
- lw r5 then add r6,r5,r1 back-to-back:
  - lw issues;
  - next cycle `op_out` = 55, `if_ready` = 0;
  - following cycle add issues.
- `ins_q[15:0]` = 0xFFFC → `imm_dpl_out` = 0xFFFFFFFC. With 0x7FFF → 0x00007FFF.
- `redirect` pulse with valid instruction latched:
  - `stop_d` = 10, `op_out` = 55;
  - next cycle `stop_d` = 01, bubble;
  - new target word issues the cycle after.
- `HALT_OP` issued → `stop_d` = 00 held indefinitely, `if_ready` = 0. Assert `rstd` → `stop_d` = 01, `op_out` = 55.
- Halt and `redirect` in the same cycle → `stop_d` = 10, FSM to FLUSH, never DONE.
